// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - rebuilds hex digits and frame status from a scanned 7-segment bus
module seg_scan_capture #(
    parameter bit         SEG_ACTIVE_LOW = 1'b1,
    parameter bit         AN_ACTIVE_LOW  = 1'b1,
    parameter int         STABLE         = 4,
    parameter logic [7:0] DIGIT_MASK     = 8'hFF
) (
    input  logic        clk_div,
    input  logic        rstn,
    input  logic [7:0]  seg,
    input  logic [7:0]  an,
    input  logic        clr_err,
    output logic [31:0] hex,
    output logic [7:0]  dp,
    output logic [7:0]  digit_valid,
    output logic        frame_valid,
    output logic [7:0]  frame_cnt,
    output logic [1:0]  err
);

    localparam logic [3:0] RUN_MAX = 4'(STABLE);
    localparam logic [3:0] RUN_CAP = 4'(STABLE - 1);

    logic [31:0] r_hex;
    logic [7:0]  r_dp;
    logic [7:0]  r_digit_valid;
    logic        r_frame_valid;
    logic [7:0]  r_frame_cnt;
    logic [1:0]  r_err;
    logic [3:0]  r_run;
    logic [15:0] r_last;
    logic [7:0]  r_seen;

    logic [7:0]  w_s;
    logic [7:0]  w_a;
    logic [15:0] w_sample;
    logic        w_same;
    logic        w_onehot;
    logic        w_multi;
    logic        w_capture;
    logic        w_glyph_ok;
    logic [3:0]  w_nibble;
    logic        w_good_cap;
    logic [7:0]  w_seen_next;
    logic        w_frame_done;
    logic [1:0]  w_err_set;
    logic [3:0]  w_run_next;

    assign w_s      = SEG_ACTIVE_LOW ? ~seg : seg;
    assign w_a      = AN_ACTIVE_LOW ? ~an : an;
    assign w_sample = {w_a, w_s};
    assign w_same   = (w_sample == r_last);

    assign w_onehot = (w_a != 8'd0) && ((w_a & (w_a - 8'd1)) == 8'd0);
    assign w_multi  = (w_a != 8'd0) && !w_onehot;

    assign w_run_next = !w_same ? 4'd1 :
                        (r_run >= RUN_MAX) ? RUN_MAX : r_run + 4'd1;

    // The run counter saturates, so this fires only once per stable run.
    assign w_capture  = w_onehot && w_same && (r_run == RUN_CAP);

    always_comb begin
        w_glyph_ok = 1'b1;
        w_nibble   = 4'h0;
        case (w_s[6:0])
            7'h3F: w_nibble = 4'h0;
            7'h06: w_nibble = 4'h1;
            7'h5B: w_nibble = 4'h2;
            7'h4F: w_nibble = 4'h3;
            7'h66: w_nibble = 4'h4;
            7'h6D: w_nibble = 4'h5;
            7'h7D: w_nibble = 4'h6;
            7'h07: w_nibble = 4'h7;
            7'h7F: w_nibble = 4'h8;
            7'h6F: w_nibble = 4'h9;
            7'h77: w_nibble = 4'hA;
            7'h7C: w_nibble = 4'hB;
            7'h39: w_nibble = 4'hC;
            7'h5E: w_nibble = 4'hD;
            7'h79: w_nibble = 4'hE;
            7'h71: w_nibble = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    assign w_good_cap   = w_capture && w_glyph_ok;
    assign w_seen_next  = r_seen | (w_good_cap ? w_a : 8'd0);
    // An empty mask would otherwise match on every edge.
    assign w_frame_done = (DIGIT_MASK != 8'd0) &&
                          ((w_seen_next & DIGIT_MASK) == DIGIT_MASK);
    assign w_err_set    = {w_multi, w_capture && !w_glyph_ok};

    always_ff @(posedge clk_div) begin
        if (!rstn) begin
            r_hex         <= 32'd0;
            r_dp          <= 8'd0;
            r_digit_valid <= 8'd0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_err         <= 2'd0;
            r_run         <= 4'd0;
            r_last        <= 16'd0;
            r_seen        <= 8'd0;
        end else begin
            r_last        <= w_sample;
            r_run         <= w_run_next;
            r_err         <= (clr_err ? 2'd0 : r_err) | w_err_set;
            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
                r_seen      <= 8'd0;
            end else begin
                r_seen      <= w_seen_next;
            end
            if (w_good_cap) begin
                for (int i = 0; i < 8; i++) begin
                    if (w_a[i]) begin
                        r_hex[4*i +: 4]  <= w_nibble;
                        r_dp[i]          <= w_s[7];
                        r_digit_valid[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign hex         = r_hex;
    assign dp          = r_dp;
    assign digit_valid = r_digit_valid;
    assign frame_valid = r_frame_valid;
    assign frame_cnt   = r_frame_cnt;
    assign err         = r_err;

endmodule
